// File: rtl/nh_lcd_frame_writer.sv
// Streams one frame of pixels to an 8-bit MIPI-DBI style LCD bus: a memory-write
// command byte, then R,G,B (RGB888) or two packed bytes (RGB565) per pixel.
module nh_lcd_frame_writer #(
   parameter logic [7:0] CMD_BYTE    = 8'h2C,
   parameter int         HOLD_CYCLES = 1,
   parameter int         COUNT_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_enable,
   input  logic                   i_enable_tearing,
   input  logic                   i_rgb565,
   input  logic [COUNT_WIDTH-1:0] i_num_pixels,
   input  logic                   i_tearing_effect,
   input  logic                   i_pix_valid,
   output logic                   o_pix_ready,
   input  logic [23:0]            i_pix_data,
   output logic                   o_cmd_mode,
   output logic                   o_write,
   output logic                   o_read,
   output logic [7:0]             o_data_out,
   output logic                   o_data_out_en,
   output logic                   o_busy,
   output logic                   o_frame_done,
   output logic [COUNT_WIDTH-1:0] o_pixel_cnt,
   output logic [15:0]            o_underrun_cnt
);

   // state        | meaning
   // S_IDLE        | waiting for i_enable with a non-zero pixel count
   // S_WAIT_TE     | frame armed, waiting for tearing-effect high
   // S_CMD         | command byte strobe (one cycle)
   // S_CMD_HOLD    | write low after the command, byte held
   // S_LOAD        | pixel handshake; stall cycles counted as underruns
   // S_BEAT        | data byte strobe (one cycle)
   // S_BEAT_HOLD   | write low after a data byte, byte held
   // S_WAIT_TE_LOW | frame finished, waiting for tearing-effect low
   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_TE,
      S_CMD,
      S_CMD_HOLD,
      S_LOAD,
      S_BEAT,
      S_BEAT_HOLD,
      S_WAIT_TE_LOW
   } state_t;

   localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES);

   state_t                 state_q, state_d;
   logic [3:0]             hold_q, hold_d;
   logic [1:0]             beat_q, beat_d;
   logic [23:0]            pix_q, pix_d;
   logic                   rgb565_q, rgb565_d;
   logic                   tearing_q, tearing_d;
   logic [COUNT_WIDTH-1:0] num_q, num_d;
   logic [COUNT_WIDTH-1:0] pixel_cnt_q, pixel_cnt_d;
   logic [15:0]            underrun_q, underrun_d;
   logic                   write_q, write_d;
   logic                   cmd_mode_q, cmd_mode_d;
   logic [7:0]             data_q, data_d;
   logic                   pix_ready_q, pix_ready_d;
   logic                   busy_q, busy_d;
   logic                   frame_done_q, frame_done_d;
   logic [1:0]             beat_last;

   function automatic logic [7:0] beat_byte(input logic [23:0] px,
                                            input logic [1:0]  idx,
                                            input logic        m565);
      logic [7:0] b;
      if (m565) begin
         b = (idx == 2'd0) ? {px[23:19], px[15:13]} : {px[12:10], px[7:3]};
      end else begin
         case (idx)
            2'd0:    b = px[23:16];
            2'd1:    b = px[15:8];
            default: b = px[7:0];
         endcase
      end
      return b;
   endfunction

   assign beat_last = rgb565_q ? 2'd1 : 2'd2;

   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      beat_d       = beat_q;
      pix_d        = pix_q;
      rgb565_d     = rgb565_q;
      tearing_d    = tearing_q;
      num_d        = num_q;
      pixel_cnt_d  = pixel_cnt_q;
      underrun_d   = underrun_q;
      frame_done_d = 1'b0;

      if (state_q != S_IDLE && !i_enable) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (i_enable && i_num_pixels != '0) begin
                  pixel_cnt_d = '0;
                  rgb565_d    = i_rgb565;
                  tearing_d   = i_enable_tearing;
                  num_d       = i_num_pixels;
                  state_d     = i_enable_tearing ? S_WAIT_TE : S_CMD;
               end
            end
            S_WAIT_TE: begin
               if (i_tearing_effect) state_d = S_CMD;
            end
            S_CMD: begin
               hold_d  = HOLD_LOAD;
               state_d = S_CMD_HOLD;
            end
            S_CMD_HOLD: begin
               if (hold_q == 4'd0) state_d = S_LOAD;
               else                hold_d  = hold_q - 4'd1;
            end
            S_LOAD: begin
               if (i_pix_valid) begin
                  pix_d       = i_pix_data;
                  pixel_cnt_d = pixel_cnt_q + COUNT_WIDTH'(1);
                  beat_d      = 2'd0;
                  state_d     = S_BEAT;
               end else if (underrun_q != 16'hFFFF) begin
                  underrun_d = underrun_q + 16'd1;
               end
            end
            S_BEAT: begin
               hold_d  = HOLD_LOAD;
               state_d = S_BEAT_HOLD;
            end
            S_BEAT_HOLD: begin
               if (hold_q != 4'd0) begin
                  hold_d = hold_q - 4'd1;
               end else if (beat_q != beat_last) begin
                  beat_d  = beat_q + 2'd1;
                  state_d = S_BEAT;
               end else if (pixel_cnt_q < num_q) begin
                  state_d = S_LOAD;
               end else begin
                  frame_done_d = 1'b1;
                  state_d      = tearing_q ? S_WAIT_TE_LOW : S_IDLE;
               end
            end
            S_WAIT_TE_LOW: begin
               if (!i_tearing_effect) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Bus outputs are decoded from the next state so the registered copies line
   // up exactly with the state they describe.
   always_comb begin
      write_d     = (state_d == S_CMD) || (state_d == S_BEAT);
      cmd_mode_d  = !((state_d == S_CMD) || (state_d == S_CMD_HOLD));
      busy_d      = (state_d != S_IDLE);
      pix_ready_d = (state_d == S_LOAD);
      data_d      = data_q;
      if (state_d == S_CMD)  data_d = CMD_BYTE;
      if (state_d == S_BEAT) data_d = beat_byte(pix_d, beat_d, rgb565_d);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         hold_q       <= 4'd0;
         beat_q       <= 2'd0;
         pix_q        <= 24'd0;
         rgb565_q     <= 1'b0;
         tearing_q    <= 1'b0;
         num_q        <= '0;
         pixel_cnt_q  <= '0;
         underrun_q   <= 16'd0;
         write_q      <= 1'b0;
         cmd_mode_q   <= 1'b1;
         data_q       <= CMD_BYTE;
         pix_ready_q  <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         beat_q       <= beat_d;
         pix_q        <= pix_d;
         rgb565_q     <= rgb565_d;
         tearing_q    <= tearing_d;
         num_q        <= num_d;
         pixel_cnt_q  <= pixel_cnt_d;
         underrun_q   <= underrun_d;
         write_q      <= write_d;
         cmd_mode_q   <= cmd_mode_d;
         data_q       <= data_d;
         pix_ready_q  <= pix_ready_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign o_write        = write_q;
   assign o_cmd_mode     = cmd_mode_q;
   assign o_data_out     = data_q;
   assign o_pix_ready    = pix_ready_q;
   assign o_busy         = busy_q;
   assign o_frame_done   = frame_done_q;
   assign o_pixel_cnt    = pixel_cnt_q;
   assign o_underrun_cnt = underrun_q;
   assign o_read         = 1'b0;
   assign o_data_out_en  = 1'b1;

endmodule

// File: tb/tb_nh_lcd_frame_writer.sv
// Self-checking bench for nh_lcd_frame_writer: directed frame table, random frames
// against a byte/timing model, plus abort, reset, restart and zero-length cases.
module tb_nh_lcd_frame_writer;

   localparam int         HOLD = 1;
   localparam logic [7:0] CMD  = 8'h2C;

   logic        clk;
   logic        rst;
   logic        i_enable, i_enable_tearing, i_rgb565, i_tearing_effect;
   logic [31:0] i_num_pixels;
   logic        i_pix_valid, o_pix_ready;
   logic [23:0] i_pix_data;
   logic        o_cmd_mode, o_write, o_read, o_data_out_en, o_busy, o_frame_done;
   logic [7:0]  o_data_out;
   logic [31:0] o_pixel_cnt;
   logic [15:0] o_underrun_cnt;

   nh_lcd_frame_writer #(.CMD_BYTE(CMD), .HOLD_CYCLES(HOLD), .COUNT_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .i_enable(i_enable), .i_enable_tearing(i_enable_tearing), .i_rgb565(i_rgb565),
      .i_num_pixels(i_num_pixels), .i_tearing_effect(i_tearing_effect),
      .i_pix_valid(i_pix_valid), .o_pix_ready(o_pix_ready), .i_pix_data(i_pix_data),
      .o_cmd_mode(o_cmd_mode), .o_write(o_write), .o_read(o_read),
      .o_data_out(o_data_out), .o_data_out_en(o_data_out_en),
      .o_busy(o_busy), .o_frame_done(o_frame_done),
      .o_pixel_cnt(o_pixel_cnt), .o_underrun_cnt(o_underrun_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { int cyc; bit cmd; logic [7:0] d; } wr_t;
   typedef struct {
      bit m565; bit te; int te_delay; int npix;
      logic [23:0] px0; logic [23:0] px1; int stall0;
      int nexp; logic [55:0] exp;
   } vec_t;

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          done_cnt = 0;
   int          exp_under = 0;
   wr_t         cap[$];
   logic [23:0] px_q[$];
   int          st_q[$];
   logic [23:0] frame_px[$];
   int          frame_st[$];
   logic [7:0]  exp_b[$];
   int          exp_g[$];
   logic        ready_prev;
   vec_t        tbl[4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // bus monitor
   initial begin
      forever begin
         wr_t w;
         @(negedge clk);
         cyc++;
         if (rst && o_write) begin
            w.cyc = cyc; w.cmd = o_cmd_mode; w.d = o_data_out;
            cap.push_back(w);
         end
         if (o_frame_done) done_cnt++;
      end
   end

   // pixel source: each queued pixel is withheld for its stall count of LOAD cycles
   initial begin
      i_pix_valid = 1'b0;
      i_pix_data  = 24'd0;
      ready_prev  = 1'b0;
      forever begin
         @(negedge clk);
         if (rst && i_pix_valid && ready_prev && px_q.size() > 0) begin
            void'(px_q.pop_front());
            void'(st_q.pop_front());
         end
         ready_prev = o_pix_ready;
         if (px_q.size() == 0) begin
            i_pix_valid = 1'b0;
         end else if (st_q[0] > 0) begin
            i_pix_valid = 1'b0;
            if (o_pix_ready) st_q[0] = st_q[0] - 1;
         end else begin
            i_pix_valid = 1'b1;
            i_pix_data  = px_q[0];
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Expected bus bytes and write-to-write spacing, from the pixel list alone.
   task automatic build_model(input bit m565);
      exp_b.delete(); exp_g.delete();
      exp_b.push_back(CMD); exp_g.push_back(0);
      foreach (frame_px[i]) begin
         int r, g, b, nb;
         r  = int'(frame_px[i]) / 65536;
         g  = (int'(frame_px[i]) / 256) % 256;
         b  = int'(frame_px[i]) % 256;
         nb = m565 ? 2 : 3;
         for (int j = 0; j < nb; j++) begin
            int v;
            if (m565) v = (j == 0) ? (r / 8) * 8 + g / 32 : ((g / 4) % 8) * 32 + b / 8;
            else      v = (j == 0) ? r : (j == 1) ? g : b;
            exp_b.push_back(8'(v));
            exp_g.push_back((j == 0) ? HOLD + 3 + frame_st[i] : HOLD + 2);
         end
      end
   endtask

   task automatic compare_frame(input string tag);
      chk({tag, "_nwrites"}, cap.size(), exp_b.size());
      for (int k = 0; k < cap.size() && k < exp_b.size(); k++) begin
         chk($sformatf("%s_byte%0d", tag, k), 32'(cap[k].d), 32'(exp_b[k]));
         chk($sformatf("%s_cmdmode%0d", tag, k), 32'(cap[k].cmd), (k == 0) ? 0 : 1);
         if (k > 0) chk($sformatf("%s_gap%0d", tag, k), cap[k].cyc - cap[k-1].cyc, exp_g[k]);
      end
   endtask

   task automatic run_frame(input string tag, input bit m565, input bit te, input int te_delay);
      bit bad, got;
      @(negedge clk);
      cap.delete(); done_cnt = 0;
      i_rgb565 = m565; i_enable_tearing = te; i_num_pixels = frame_px.size();
      i_tearing_effect = 1'b0; i_enable = 1'b1;
      if (te) begin
         bad = 1'b0;
         repeat (te_delay) begin
            @(negedge clk);
            if (o_write || !o_busy) bad = 1'b1;
         end
         chk({tag, "_te_wait_quiet"}, 32'(bad), 0);
         i_tearing_effect = 1'b1;
      end
      got = 1'b0;
      for (int c = 0; c < 3000 && !got; c++) begin
         @(negedge clk);
         got = o_frame_done;
      end
      chk({tag, "_done_seen"}, 32'(got), 1);
      if (te) begin
         bad = 1'b0;
         repeat (3) begin
            @(negedge clk);
            if (!o_busy || o_write || o_pix_ready) bad = 1'b1;
         end
         chk({tag, "_te_low_hold"}, 32'(bad), 0);
         i_tearing_effect = 1'b0;
         @(negedge clk);
         chk({tag, "_te_low_exit"}, 32'(o_busy), 0);
      end
      i_enable = 1'b0;
      repeat (3) @(negedge clk);
      chk({tag, "_done_pulses"}, done_cnt, 1);
      chk({tag, "_busy_after"}, 32'(o_busy), 0);
      chk({tag, "_pixel_cnt"}, o_pixel_cnt, frame_px.size());
      chk({tag, "_underrun"}, 32'(o_underrun_cnt), exp_under);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_write"},     32'(o_write), 0);
      chk({tag, "_cmd_mode"},  32'(o_cmd_mode), 1);
      chk({tag, "_data_out"},  32'(o_data_out), 32'(CMD));
      chk({tag, "_pix_ready"}, 32'(o_pix_ready), 0);
      chk({tag, "_busy"},      32'(o_busy), 0);
      chk({tag, "_done"},      32'(o_frame_done), 0);
      chk({tag, "_pixel_cnt"}, o_pixel_cnt, 0);
      chk({tag, "_underrun"},  32'(o_underrun_cnt), 0);
      chk({tag, "_read"},      32'(o_read), 0);
      chk({tag, "_data_en"},   32'(o_data_out_en), 1);
   endtask

   initial begin
      bit   bad, got;
      int   nd;

      tbl[0] = '{1'b0, 1'b0, 0,  2, 24'h112233, 24'h445566, 0, 7, 56'h2C112233445566};
      tbl[1] = '{1'b1, 1'b0, 0,  2, 24'hF8FCF8, 24'h080408, 0, 5, 56'h2CFFFF0821};
      tbl[2] = '{1'b0, 1'b1, 10, 1, 24'hA1B2C3, 24'h000000, 5, 4, 56'h2CA1B2C3};
      tbl[3] = '{1'b1, 1'b1, 3,  1, 24'h123456, 24'h000000, 2, 3, 56'h2C11AA};

      rst = 1'b0; i_enable = 1'b0; i_enable_tearing = 1'b0; i_rgb565 = 1'b0;
      i_num_pixels = 32'd0; i_tearing_effect = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst = 1'b1;

      // directed frames from the table
      for (int i = 0; i < 4; i++) begin
         px_q.delete(); st_q.delete();
         px_q.push_back(tbl[i].px0); st_q.push_back(tbl[i].stall0);
         if (tbl[i].npix == 2) begin px_q.push_back(tbl[i].px1); st_q.push_back(0); end
         frame_px = px_q; frame_st = st_q;
         build_model(tbl[i].m565);
         exp_b.delete();
         for (int k = 0; k < tbl[i].nexp; k++)
            exp_b.push_back(tbl[i].exp[8*(tbl[i].nexp-1-k) +: 8]);
         exp_under += tbl[i].stall0;
         run_frame($sformatf("tbl%0d", i), tbl[i].m565, tbl[i].te, tbl[i].te_delay);
         compare_frame($sformatf("tbl%0d", i));
      end

      // random frames against the model
      for (int r = 0; r < 8; r++) begin
         bit m565, te;
         int n;
         m565 = 1'($urandom_range(0, 1));
         te   = 1'($urandom_range(0, 1));
         n    = $urandom_range(1, 5);
         px_q.delete(); st_q.delete();
         for (int p = 0; p < n; p++) begin
            px_q.push_back(24'($urandom));
            st_q.push_back($urandom_range(0, 3));
         end
         frame_px = px_q; frame_st = st_q;
         foreach (frame_st[p]) exp_under += frame_st[p];
         build_model(m565);
         run_frame($sformatf("rnd%0d", r), m565, te, $urandom_range(1, 6));
         compare_frame($sformatf("rnd%0d", r));
      end

      // zero pixel count never starts a frame
      @(negedge clk);
      cap.delete(); i_enable_tearing = 1'b0; i_num_pixels = 32'd0; i_enable = 1'b1;
      bad = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (o_busy || o_write) bad = 1'b1;
      end
      chk("zero_pix_idle", 32'(bad), 0);
      i_enable = 1'b0;

      // automatic restart while enable stays high
      px_q.delete(); st_q.delete();
      px_q.push_back(24'hCAFE01); px_q.push_back(24'h10AB77);
      st_q.push_back(0); st_q.push_back(0);
      @(negedge clk);
      cap.delete(); done_cnt = 0;
      i_rgb565 = 1'b0; i_enable_tearing = 1'b0; i_num_pixels = 32'd1; i_enable = 1'b1;
      nd = 0;
      for (int c = 0; c < 500 && nd < 2; c++) begin
         @(negedge clk);
         if (o_frame_done) nd++;
      end
      i_enable = 1'b0;
      repeat (3) @(negedge clk);
      chk("restart_done_pulses", done_cnt, 2);
      chk("restart_nwrites", cap.size(), 8);
      if (cap.size() == 8) begin
         chk("restart_cmd2_mode", 32'(cap[4].cmd), 0);
         chk("restart_cmd2_byte", 32'(cap[4].d), 32'(CMD));
         chk("restart_px2_r", 32'(cap[5].d), 32'h10);
      end

      // enable dropped right after the first data beat
      px_q.delete(); st_q.delete();
      for (int p = 0; p < 3; p++) begin px_q.push_back(24'h1234AB + 24'(p)); st_q.push_back(0); end
      @(negedge clk);
      cap.delete(); done_cnt = 0;
      i_rgb565 = 1'b0; i_enable_tearing = 1'b0; i_num_pixels = 32'd3; i_enable = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 200 && !got; c++) begin
         @(negedge clk);
         got = o_write && o_cmd_mode;
      end
      chk("abort_first_beat_seen", 32'(got), 1);
      i_enable = 1'b0;
      @(negedge clk);
      chk("abort_busy", 32'(o_busy), 0);
      bad = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (o_write || o_busy) bad = 1'b1;
      end
      chk("abort_quiet", 32'(bad), 0);
      chk("abort_no_done", done_cnt, 0);
      chk("abort_nwrites", cap.size(), 2);
      px_q.delete(); st_q.delete();

      // reset in the middle of a stalled frame
      for (int p = 0; p < 4; p++) begin px_q.push_back(24'hABCDEF); st_q.push_back(3); end
      @(negedge clk);
      done_cnt = 0;
      i_rgb565 = 1'b1; i_num_pixels = 32'd4; i_enable = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 200 && !got; c++) begin
         @(negedge clk);
         got = o_write && o_cmd_mode;
      end
      chk("midrst_beat_seen", 32'(got), 1);
      repeat (2) @(negedge clk);
      rst = 1'b0; i_enable = 1'b0;
      px_q.delete(); st_q.delete();
      @(negedge clk);
      check_reset_vals("midrst");
      rst = 1'b1;
      repeat (5) @(negedge clk);
      chk("midrst_no_done", done_cnt, 0);
      chk("midrst_idle", 32'(o_busy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/nh_lcd_frame_writer.md
NH_LCD_FRAME_WRITER -- requirements
Module: nh_lcd_frame_writer

Interface
REQ-001 SHALL provide parameter CMD_BYTE, default 8'h2C, meaning the memory-write command byte issued at frame start.
REQ-002 SHALL provide parameter HOLD_CYCLES, default 1, range 0..15, meaning the number of extra write-low cycles per bus beat.
REQ-003 SHALL provide parameter COUNT_WIDTH, default 32, meaning the width of the pixel count and pixel counter.
REQ-004 SHALL have one clock and a synchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-005 SHALL have rst  in  1  synchronous active-low reset; rst=0 sampled on a clk edge resets the block.
REQ-006 SHALL have i_enable  in  1  level; frames run while high.
REQ-007 SHALL have i_enable_tearing  in  1  level; 1 = frame start gated by tearing effect.
REQ-008 SHALL have i_rgb565  in  1  mode; 0 = RGB888 (3 beats/pixel), 1 = RGB565 (2 beats/pixel); sampled at frame start only.
REQ-009 SHALL have i_num_pixels  in  COUNT_WIDTH  pixels per frame; sampled at frame start.
REQ-010 SHALL have i_tearing_effect  in  1  panel TE line, already synchronous to clk.
REQ-011 SHALL have i_pix_valid  in  1, o_pix_ready  out  1, i_pix_data  in  24  {R[23:16],G[15:8],B[7:0]} pixel stream.
REQ-012 SHALL have o_cmd_mode  out  1 (0 = command byte, 1 = data), o_write  out  1 (write strobe), o_data_out  out  8 (bus byte).
REQ-013 SHALL have o_read  out  1 tied 0 and o_data_out_en  out  1 tied 1.
REQ-014 SHALL have o_busy  out  1, o_frame_done  out  1 (pulse), o_pixel_cnt  out  COUNT_WIDTH, o_underrun_cnt  out  16.

Function
REQ-015 SHALL implement states IDLE, WAIT_TE, CMD, CMD_HOLD, LOAD, BEAT, BEAT_HOLD, WAIT_TE_LOW.
REQ-016 IDLE: when i_enable=1 and i_num_pixels!=0, SHALL clear o_pixel_cnt, latch i_rgb565/i_num_pixels, then go to WAIT_TE if i_enable_tearing=1, else CMD; if i_num_pixels=0, SHALL stay in IDLE.
REQ-017 WAIT_TE: SHALL go to CMD on the first cycle i_tearing_effect=1.
REQ-018 CMD: o_write=1, o_cmd_mode=0, o_data_out=CMD_BYTE for exactly one cycle; then CMD_HOLD for HOLD_CYCLES+1 cycles with o_write=0, o_cmd_mode=0, o_data_out unchanged; then LOAD.
REQ-019 LOAD: o_pix_ready=1 only in this state; on i_pix_valid=1, SHALL capture pixel, increment o_pixel_cnt and go to BEAT.
REQ-020 LOAD with i_pix_valid=0: SHALL stay and increment o_underrun_cnt once per stall cycle, saturating at 16'hFFFF; counter cleared only by reset.
REQ-021 BEAT: one cycle, o_write=1, o_cmd_mode=1, o_data_out=current beat; BEAT_HOLD: HOLD_CYCLES+1 cycles, o_write=0, data held.
REQ-022 RGB888 beat order SHALL be R, G, B; RGB565 SHALL be {R[7:3],G[7:5]} then {G[4:2],B[7:3]}.
REQ-023 After the last beat's hold: if o_pixel_cnt < latched count, SHALL go to LOAD; else SHALL pulse o_frame_done for one cycle and go to WAIT_TE_LOW (tearing on) or IDLE (tearing off).
REQ-024 WAIT_TE_LOW: SHALL go to IDLE on the first cycle i_tearing_effect=0.
REQ-025 i_enable=0 in any non-IDLE state SHALL abort to IDLE on the next edge, with o_write=0, o_cmd_mode=1 and no o_frame_done.
REQ-026 o_busy SHALL be 1 in every state except IDLE.
REQ-027 Outside CMD/CMD_HOLD, o_cmd_mode SHALL be 1; o_write SHALL be 1 only in CMD and BEAT.
REQ-028 All outputs SHALL be registered; beat period SHALL be HOLD_CYCLES+2 cycles.
REQ-029 With i_enable still 1 after a frame, a new frame SHALL start from IDLE automatically.

Reset
REQ-030 While rst=0 on a clk edge: state=IDLE, o_write=0, o_cmd_mode=1, o_data_out=CMD_BYTE, o_pix_ready=0, o_busy=0, o_frame_done=0, o_pixel_cnt=0, o_underrun_cnt=0.
REQ-031 Reset asserted mid-frame SHALL override all transitions; no o_frame_done SHALL be issued.

Verification
REQ-032 Tearing off, RGB888, HOLD_CYCLES=1, num_pixels=2, pixels 0x112233/0x445566 always valid -> one cmd write 0x2C (cmd_mode=0), then data writes 11,22,33,44,55,66 each 3 cycles apart, o_frame_done one pulse.
REQ-033 RGB565, pixel 0xF8FC F8 -> data bytes 0xFF, 0xFF; pixel 0x0804 08 -> 0x08, 0x21.
REQ-034 Tearing on, TE low 10 cycles then high -> no o_write until TE=1; after last pixel, state held in WAIT_TE_LOW until TE=0.
REQ-035 i_pix_valid withheld 5 cycles in LOAD -> o_underrun_cnt increases by 5, no o_write during stall.
REQ-036 i_enable dropped after 1st data beat -> o_busy=0 next cycle, no further writes, no o_frame_done; rst=0 mid-frame -> all REQ-030 values.
REQ-037 i_num_pixels=0 with i_enable=1 -> no writes, o_busy stays 0.
